// File: rtl/rtc_edit_ctrl.sv
// RTC set-time edit sequencer: field select, up/down strobes with auto-repeat, blink.
// Optional EDIT_TIMEOUT_EN adds an inactivity auto-exit after TIMEOUT idle cycles.
module rtc_edit_ctrl #(
    parameter int NUM_FIELDS    = 6,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 25000000,
    parameter int BLINK_DIV     = 25000000,
    parameter int TIMEOUT       = 1000000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_edit,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       edit_active,
    output logic       blink
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
    localparam int BW   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    localparam logic [3:0]    NF   = 4'(NUM_FIELDS);
    localparam logic [RW-1:0] DLIM = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PLIM = RW'(REPEAT_PERIOD - 1);
    localparam logic [BW-1:0] BLIM = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {IDLE, EDIT, HOLD, REPEAT} state_t;

    state_t        state, state_n;
    logic          dir_up, dir_up_n;
    logic [RW-1:0] rcnt, rcnt_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [3:0]    ec_n;
    logic          up_n, dn_n, act_n, bl_n;
    logic          p_edit, p_left, p_right, p_up, p_down;
    logic          r_edit, r_left, r_right, r_up, r_down;
    logic          field_chg, go_idle;
    logic          act_btn, opp_btn;

`ifdef EDIT_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
    logic [TW-1:0] tcnt, tcnt_n;
`endif

    assign r_edit  = btn_edit  & ~p_edit;
    assign r_left  = btn_left  & ~p_left;
    assign r_right = btn_right & ~p_right;
    assign r_up    = btn_up    & ~p_up;
    assign r_down  = btn_down  & ~p_down;

    assign act_btn = dir_up ? btn_up   : btn_down;
    assign opp_btn = dir_up ? btn_down : btn_up;

    always_comb begin
        state_n   = state;
        dir_up_n  = dir_up;
        rcnt_n    = rcnt;
        ec_n      = en_count;
        up_n      = 1'b0;
        dn_n      = 1'b0;
        act_n     = edit_active;
        field_chg = 1'b0;
        go_idle   = 1'b0;
        unique case (state)
            IDLE: begin
                if (r_edit) begin
                    state_n   = EDIT;
                    ec_n      = 4'd1;
                    act_n     = 1'b1;
                    field_chg = 1'b1;
                end
            end
            EDIT: begin
                if (r_edit) begin
                    go_idle = 1'b1;
                end else if (r_up & ~btn_down) begin
                    up_n     = 1'b1;
                    dir_up_n = 1'b1;
                    rcnt_n   = '0;
                    state_n  = HOLD;
                end else if (r_down & ~btn_up) begin
                    dn_n     = 1'b1;
                    dir_up_n = 1'b0;
                    rcnt_n   = '0;
                    state_n  = HOLD;
                end else if (r_right & ~r_left) begin
                    ec_n      = (en_count == NF) ? 4'd1 : en_count + 4'd1;
                    field_chg = 1'b1;
                end else if (r_left & ~r_right) begin
                    ec_n      = (en_count == 4'd1) ? NF : en_count - 4'd1;
                    field_chg = 1'b1;
                end
            end
            HOLD, REPEAT: begin
                if (r_edit) begin
                    go_idle = 1'b1;
                end else if (~act_btn | opp_btn) begin
                    state_n = EDIT;
                    rcnt_n  = '0;
                end else if (rcnt == ((state == HOLD) ? DLIM : PLIM)) begin
                    up_n    = dir_up;
                    dn_n    = ~dir_up;
                    rcnt_n  = '0;
                    state_n = REPEAT;
                end else begin
                    rcnt_n = rcnt + RW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef EDIT_TIMEOUT_EN
        // Any edge or strobe counts as activity; otherwise count toward auto-exit.
        tcnt_n = tcnt + TW'(1);
        if (state == IDLE || r_edit || r_left || r_right || r_up || r_down || up_n || dn_n)
            tcnt_n = '0;
        else if (tcnt == TLIM) begin
            go_idle = 1'b1;
            tcnt_n  = '0;
        end
`endif

        if (go_idle) begin
            state_n   = IDLE;
            ec_n      = 4'd0;
            act_n     = 1'b0;
            up_n      = 1'b0;
            dn_n      = 1'b0;
            rcnt_n    = '0;
            field_chg = 1'b0;
        end

        bl_n   = blink;
        bcnt_n = bcnt;
        if (!act_n) begin
            bl_n   = 1'b0;
            bcnt_n = '0;
        end else if (field_chg) begin
            bl_n   = 1'b1;
            bcnt_n = '0;
        end else if (bcnt == BLIM) begin
            bl_n   = ~blink;
            bcnt_n = '0;
        end else begin
            bcnt_n = bcnt + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dir_up      <= 1'b0;
            rcnt        <= '0;
            bcnt        <= '0;
            en_count    <= 4'd0;
            enUP        <= 1'b0;
            enDOWN      <= 1'b0;
            edit_active <= 1'b0;
            blink       <= 1'b0;
            p_edit      <= 1'b0;
            p_left      <= 1'b0;
            p_right     <= 1'b0;
            p_up        <= 1'b0;
            p_down      <= 1'b0;
        end else begin
            state       <= state_n;
            dir_up      <= dir_up_n;
            rcnt        <= rcnt_n;
            bcnt        <= bcnt_n;
            en_count    <= ec_n;
            enUP        <= up_n;
            enDOWN      <= dn_n;
            edit_active <= act_n;
            blink       <= bl_n;
            p_edit      <= btn_edit;
            p_left      <= btn_left;
            p_right     <= btn_right;
            p_up        <= btn_up;
            p_down      <= btn_down;
        end
    end

`ifdef EDIT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) tcnt <= '0;
        else       tcnt <= tcnt_n;
    end
`endif

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
// Scoreboard bench for rtc_edit_ctrl: timestamp-based reference model feeds an
// expectation queue; a negedge monitor pops and compares every cycle.
module tb_rtc_edit_ctrl;

    localparam int NF = 6;
    localparam int RD = 8;
    localparam int RP = 4;
    localparam int BD = 5;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       reset, btn_edit, btn_left, btn_right, btn_up, btn_down;
    logic [3:0] en_count;
    logic       enUP, enDOWN, edit_active, blink;

    rtc_edit_ctrl #(
        .NUM_FIELDS(NF), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .BLINK_DIV(BD), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .btn_edit(btn_edit), .btn_left(btn_left),
        .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
        .edit_active(edit_active), .blink(blink)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ec;
        logic       up;
        logic       dn;
        logic       act;
        logic       bl;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: edge index plus timestamps of key events.
    int t = 0;
    bit m_edit;
    int m_field;
    int m_dir;
    int press_t, chg_t, act_t;
    bit p_e, p_l, p_r, p_u, p_d;

    task automatic chk(input string nm, input logic [3:0] a, input logic [3:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, a, e);
        end
    endtask

    task automatic leave_edit();
        m_edit  = 0;
        m_field = 0;
        m_dir   = 0;
    endtask

    task automatic step(input bit r, input bit e, input bit l, input bit rt,
                        input bit u, input bit d);
        exp_t x;
        bit re, rl, rr, ru, rdn, su, sd;
        int h;
        su = 0;
        sd = 0;
        reset = r; btn_edit = e; btn_left = l;
        btn_right = rt; btn_up = u; btn_down = d;
        t++;
        if (r) begin
            leave_edit();
            {p_e, p_l, p_r, p_u, p_d} = '0;
        end else begin
            re = e & !p_e; rl = l & !p_l; rr = rt & !p_r;
            ru = u & !p_u; rdn = d & !p_d;
            if (!m_edit) begin
                if (re) begin
                    m_edit = 1; m_field = 1; m_dir = 0;
                    chg_t = t; act_t = t;
                end
            end else if (re) begin
                leave_edit();
            end else begin
                if (m_dir == 0) begin
                    if (ru && !d) begin
                        su = 1; m_dir = 1; press_t = t;
                    end else if (rdn && !u) begin
                        sd = 1; m_dir = -1; press_t = t;
                    end else if (rr && !rl) begin
                        m_field = (m_field % NF) + 1; chg_t = t;
                    end else if (rl && !rr) begin
                        m_field = (m_field == 1) ? NF : m_field - 1; chg_t = t;
                    end
                end else begin
                    if ((m_dir > 0) ? (!u || d) : (!d || u)) m_dir = 0;
                    else begin
                        h = t - press_t;
                        if (h >= RD && ((h - RD) % RP) == 0) begin
                            su = (m_dir > 0);
                            sd = (m_dir < 0);
                        end
                    end
                end
`ifdef EDIT_TIMEOUT_EN
                if (rl || rr || ru || rdn || su || sd) act_t = t;
                else if (t - act_t == TO) leave_edit();
`endif
            end
            {p_e, p_l, p_r, p_u, p_d} = {e, l, rt, u, d};
        end
        x.ec  = 4'(m_field);
        x.up  = su;
        x.dn  = sd;
        x.act = m_edit;
        x.bl  = m_edit && ((((t - chg_t) / BD) % 2) == 0);
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("en_count", en_count, x.ec);
            chk("enUP", {3'b0, enUP}, {3'b0, x.up});
            chk("enDOWN", {3'b0, enDOWN}, {3'b0, x.dn});
            chk("edit_active", {3'b0, edit_active}, {3'b0, x.act});
            chk("blink", {3'b0, blink}, {3'b0, x.bl});
        end
    end

    initial begin
        bit ce, cl, cr, cu, cd, cr_;
        repeat (3) step(1, 0, 0, 0, 0, 0);
        idle(2);
        // enter / leave edit mode
        step(0, 1, 0, 0, 0, 0); idle(3);
        step(0, 1, 0, 0, 0, 0); idle(3);
        // field navigation with wrap
        step(0, 1, 0, 0, 0, 0); idle(1);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 0, 0); idle(2);
        end
        step(0, 0, 1, 0, 0, 0); idle(2);
        // hold-to-repeat
        repeat (30) step(0, 0, 0, 0, 1, 0);
        idle(3);
        // opposite button during hold, then both together
        repeat (12) step(0, 0, 0, 0, 1, 0);
        repeat (6) step(0, 0, 0, 0, 1, 1);
        idle(2);
        repeat (3) step(0, 0, 0, 0, 1, 1);
        idle(2);
        // down repeat, then edit pulse during REPEAT
        repeat (14) step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0, 0, 1);
        idle(2);
        // reset mid-hold
        step(0, 1, 0, 0, 0, 0); idle(1);
        repeat (4) step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        idle(2);
        // long idle in edit mode
        step(0, 1, 0, 0, 0, 0);
        idle(100);
        // randomized stretch
        {ce, cl, cr, cu, cd} = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) ce = !ce;
            if ($urandom_range(0, 7) == 0) cl = !cl;
            if ($urandom_range(0, 7) == 0) cr = !cr;
            if ($urandom_range(0, 11) == 0) cu = !cu;
            if ($urandom_range(0, 11) == 0) cd = !cd;
            cr_ = ($urandom_range(0, 299) == 0);
            step(cr_, ce, cl, cr, cu, cd);
        end
        idle(1);
        @(negedge clk);
        #1;
        chk("queue_drained", 4'(q.size()), 4'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
